// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch controller between the PC logic and a
// 2^AW x DW instruction memory with a 1-cycle registered read. Issues FETCH
// strobes, captures the returning byte one cycle later into a 2-entry
// prefetch queue, and presents the queue head to the decoder over a
// valid/ready handshake. Supports start, branch redirect with flush and
// halt-with-drain.
//
// Optional build macro: IFETCH_WRAP_FAULT_EN
//   defined   -> issuing a fetch at the top address sets a sticky fault and
//                drains the queue into HALT after that fetch.
//   undefined -> the PC wraps silently and fault is tied low.
module ifetch_ctrl #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int QDEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  output logic [AW-1:0] iAddr,
  output logic          FETCH,
  input  logic [DW-1:0] instr,
  output logic [DW-1:0] ins_out,
  output logic [AW-1:0] ins_pc,
  output logic          ins_valid,
  input  logic          ins_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  input  logic          halt_req,
  output logic          busy,
  output logic          fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  // Queue capacity used by the issue throttle; the queue itself is 2 deep.
  localparam logic [2:0] QFULL = 3'(QDEPTH);

  logic [1:0]    state;
  logic [AW-1:0] pc;

  // Fetch-in-flight stage: memory data for this address arrives next cycle.
  logic          vld_p1;
  logic [AW-1:0] addr_p1;

  // Prefetch queue storage and bookkeeping.
  logic [DW-1:0] q_data [2];
  logic [AW-1:0] q_addr [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;

  logic          in_run;
  logic          active;
  logic          start_ok;
  logic          redir;
  logic          pop;
  logic          push;
  logic          issue;
  logic          wrap_hit;
  logic [2:0]    occ;

  function automatic logic [AW-1:0] pc_next(input logic [AW-1:0] a);
    return a + AW'(1);
  endfunction

  assign in_run   = (state == S_RUN);
  assign active   = in_run || (state == S_DRAIN);
  assign start_ok = start && !active;
  assign redir    = redirect && active;

  assign ins_valid = active && (count != 2'd0);
  assign pop       = ins_valid && ins_ready;

  // Data returning in a redirect cycle belongs to the abandoned path.
  assign push = vld_p1 && !redir;

  // Slots committed after this cycle's pop: queued entries plus the one in flight.
  assign occ   = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue = in_run && !redirect && (occ < QFULL);

  assign FETCH   = issue;
  assign iAddr   = in_run ? pc : '0;
  assign ins_out = ins_valid ? q_data[rd_ptr] : '0;
  assign ins_pc  = ins_valid ? q_addr[rd_ptr] : '0;
  assign busy    = active;

`ifdef IFETCH_WRAP_FAULT_EN
  logic fault_q;

  assign wrap_hit = issue && (pc == {AW{1'b1}});
  assign fault    = fault_q;

  // Sticky wrap fault, cleared only by reset or an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (start_ok) begin
      fault_q <= 1'b0;
    end else if (wrap_hit) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign wrap_hit = 1'b0;
  assign fault    = 1'b0;
`endif

  // Control path: FSM, program counter, in-flight flag and queue occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc     <= '0;
      vld_p1 <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      vld_p1 <= issue;

      if (start_ok) begin
        pc <= start_addr;
      end else if (redir) begin
        pc <= redirect_addr;
      end else if (issue) begin
        pc <= pc_next(pc);
      end

      if (start_ok || redir) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end

      case (state)
        S_IDLE, S_HALT: begin
          if (start) state <= S_RUN;
        end
        S_RUN: begin
          // Redirect wins; a concurrent halt_req is looked at again next cycle.
          if (!redirect && (halt_req || wrap_hit)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (redirect || (count == 2'd0 && !vld_p1)) state <= S_HALT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- stage p0 -> p1: hold the issued address until its data returns ----
  // ---- stage p1 -> queue: write the returning byte with its address ----
  // Datapath registers carry no reset; they are only read when qualified.
  always_ff @(posedge clk) begin
    if (issue) addr_p1 <= pc;
    if (push) begin
      q_data[wr_ptr] <= instr;
      q_addr[wr_ptr] <= addr_p1;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl: directed scenarios plus a randomized run, all
// checked against a transaction-level reference model (fetch order, 2-cycle
// fetch-to-visible latency, 2-slot outstanding limit, mode rules).
module tb_ifetch_ctrl;

`ifdef IFETCH_WRAP_FAULT_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HALT  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] start_addr = 8'h00;
  logic [7:0] iAddr;
  logic       FETCH;
  logic [7:0] instr = 8'h00;
  logic [7:0] ins_out;
  logic [7:0] ins_pc;
  logic       ins_valid;
  logic       ins_ready = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_addr = 8'h00;
  logic       halt_req = 1'b0;
  logic       busy;
  logic       fault;

  logic [7:0] mem [256];

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] addr;
    int         t;
  } ent_t;

  // Reference model: fetched-but-undelivered addresses with the cycle each
  // becomes visible to the decoder.
  ent_t       m_dq[$];
  int         m_mode = M_IDLE;
  int         m_cyc = 0;
  logic [7:0] m_fpc = 8'h00;
  logic       m_fault = 1'b0;

  logic       e_valid, e_pop, e_fetch, e_busy;
  logic [7:0] e_pc, e_out, e_iaddr;
  int         obs_out = 0;

  ifetch_ctrl #(.AW(8), .DW(8), .QDEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .iAddr         (iAddr),
    .FETCH         (FETCH),
    .instr         (instr),
    .ins_out       (ins_out),
    .ins_pc        (ins_pc),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt_req      (halt_req),
    .busy          (busy),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  // Instruction memory with a registered read port.
  always @(posedge clk) begin
    if (FETCH) instr <= mem[iAddr];
  end

  task automatic model_reset();
    m_dq.delete();
    m_mode  = M_IDLE;
    m_fpc   = 8'h00;
    m_fault = 1'b0;
    obs_out = 0;
  endtask

  // Expected outputs for the current cycle given the inputs now applied.
  task automatic model_eval();
    e_valid = 1'b0;
    e_pc    = 8'h00;
    if ((m_mode == M_RUN || m_mode == M_DRAIN) && m_dq.size() > 0) begin
      if (m_dq[0].t <= m_cyc) begin
        e_valid = 1'b1;
        e_pc    = m_dq[0].addr;
      end
    end
    e_out   = mem[e_pc];
    e_pop   = e_valid && ins_ready;
    e_fetch = (m_mode == M_RUN) && !redirect &&
              ((int'(m_dq.size()) - (e_pop ? 1 : 0)) < 2);
    e_iaddr = m_fpc;
    e_busy  = (m_mode == M_RUN || m_mode == M_DRAIN);
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_advance();
    int   prev;
    bit   was_empty;
    ent_t e;
    prev      = m_mode;
    was_empty = (m_dq.size() == 0);
    if (prev == M_IDLE || prev == M_HALT) begin
      if (start) begin
        m_dq.delete();
        m_fpc   = start_addr;
        m_fault = 1'b0;
        m_mode  = M_RUN;
      end
    end else if (redirect) begin
      m_dq.delete();
      m_fpc = redirect_addr;
      if (prev == M_DRAIN) m_mode = M_HALT;
    end else begin
      if (e_pop) void'(m_dq.pop_front());
      if (e_fetch) begin
        e.addr = m_fpc;
        e.t    = m_cyc + 2;
        m_dq.push_back(e);
        if (WRAP_EN && m_fpc == 8'hFF) begin
          m_fault = 1'b1;
          m_mode  = M_DRAIN;
        end
        m_fpc = m_fpc + 8'd1;
      end
      if (prev == M_RUN && halt_req) m_mode = M_DRAIN;
      else if (prev == M_DRAIN && was_empty) m_mode = M_HALT;
    end
    m_cyc++;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    redirect = 1'b0;
    halt_req = 1'b0;
  endtask

  // Hold the decoder off for three cycles so the queue ends up holding two entries.
  task automatic fill_queue();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_inputs();
      ins_ready = 1'b0;
      settle();
      model_advance();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({FETCH, iAddr, ins_valid, ins_out, ins_pc, busy, fault} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: FETCH=%0b iAddr=%0h valid=%0b out=%0h pc=%0h busy=%0b fault=%0b, want all 0",
               FETCH, iAddr, ins_valid, ins_out, ins_pc, busy, fault);
    end
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    model_advance();
  endtask

  task automatic test_start();
    ins_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle_inputs();
      start      = (c == 0);
      start_addr = 8'h10;
      settle();
      case (c)
        0: begin
          vectors++;
          if (FETCH !== 1'b0) begin
            miscompares++;
            $display("FAIL start_c0_fetch: got %0b want 0", FETCH);
          end
        end
        1, 2: begin
          vectors++;
          if ({FETCH, iAddr, busy} !== {1'b1, 8'(8'h10 + c - 1), 1'b1}) begin
            miscompares++;
            $display("FAIL start_fetch_c%0d: FETCH=%0b iAddr=%0h busy=%0b want 1/%0h/1",
                     c, FETCH, iAddr, busy, 8'(8'h10 + c - 1));
          end
          vectors++;
          if (ins_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL start_valid_c%0d: got %0b want 0", c, ins_valid);
          end
        end
        default: begin
          vectors++;
          if ({ins_valid, ins_pc, ins_out} !== {1'b1, 8'(8'h10 + c - 3), 8'(8'h10 + c - 3)}) begin
            miscompares++;
            $display("FAIL start_deliver_c%0d: valid=%0b pc=%0h out=%0h want 1/%0h/%0h",
                     c, ins_valid, ins_pc, ins_out, 8'(8'h10 + c - 3), 8'(8'h10 + c - 3));
          end
        end
      endcase
      model_advance();
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      idle_inputs();
      ins_ready = (c >= 4);
      settle();
      if (c < 4) begin
        vectors++;
        if ({FETCH, ins_valid, ins_pc} !== {1'b0, 1'b1, 8'h13}) begin
          miscompares++;
          $display("FAIL bp_hold_c%0d: FETCH=%0b valid=%0b pc=%0h want 0/1/13", c, FETCH, ins_valid, ins_pc);
        end
      end else begin
        vectors++;
        if ({ins_valid, ins_pc, ins_out} !== {1'b1, 8'(8'h13 + c - 4), 8'(8'h13 + c - 4)}) begin
          miscompares++;
          $display("FAIL bp_release_c%0d: valid=%0b pc=%0h out=%0h want 1/%0h", c, ins_valid, ins_pc, ins_out,
                   8'(8'h13 + c - 4));
        end
      end
      model_advance();
    end
  endtask

  task automatic test_redirect();
    fill_queue();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      idle_inputs();
      redirect      = (c == 0);
      redirect_addr = 8'h80;
      ins_ready     = (c != 0);
      settle();
      case (c)
        0: begin
          vectors++;
          if (FETCH !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_suppress: FETCH=%0b want 0", FETCH);
          end
        end
        1: begin
          vectors++;
          if ({ins_valid, FETCH, iAddr} !== {1'b0, 1'b1, 8'h80}) begin
            miscompares++;
            $display("FAIL redir_next: valid=%0b FETCH=%0b iAddr=%0h want 0/1/80", ins_valid, FETCH, iAddr);
          end
        end
        2: begin
          vectors++;
          if (ins_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_gap: valid=%0b want 0", ins_valid);
          end
        end
        default: begin
          vectors++;
          if ({ins_valid, ins_pc, ins_out} !== {1'b1, 8'(8'h80 + c - 3), 8'(8'h80 + c - 3)}) begin
            miscompares++;
            $display("FAIL redir_target_c%0d: valid=%0b pc=%0h out=%0h want 1/%0h", c, ins_valid, ins_pc, ins_out,
                     8'(8'h80 + c - 3));
          end
        end
      endcase
      model_advance();
    end
  endtask

  task automatic test_halt();
    logic [7:0] got[$];
    bit         fell;
    fill_queue();
    @(negedge clk);
    idle_inputs();
    halt_req  = 1'b1;
    ins_ready = 1'b0;
    settle();
    vectors++;
    if ({FETCH, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL halt_req_cycle: FETCH=%0b busy=%0b want 0/1", FETCH, busy);
    end
    model_advance();
    fell = 1'b0;
    for (int c = 0; c < 10 && !fell; c++) begin
      @(negedge clk);
      idle_inputs();
      ins_ready = 1'b1;
      settle();
      vectors++;
      if (FETCH !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_drain_fetch_c%0d: FETCH=%0b want 0", c, FETCH);
      end
      if (ins_valid === 1'b1) got.push_back(ins_pc);
      if (busy === 1'b0) fell = 1'b1;
      model_advance();
    end
    vectors++;
    if (!fell) begin
      miscompares++;
      $display("FAIL halt_busy_timeout: busy=%0b want 0 within 10 cycles", busy);
    end
    vectors++;
    if (got.size() != 2) begin
      miscompares++;
      $display("FAIL halt_drain_count: got %0d entries want 2", got.size());
    end else if (got[0] !== 8'h82 || got[1] !== 8'h83) begin
      miscompares++;
      $display("FAIL halt_drain_order: got %0h,%0h want 82,83", got[0], got[1]);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_inputs();
      start      = (c == 0);
      start_addr = 8'h05;
      ins_ready  = 1'b1;
      settle();
      if (c == 1) begin
        vectors++;
        if ({FETCH, iAddr} !== {1'b1, 8'h05}) begin
          miscompares++;
          $display("FAIL halt_restart_fetch: FETCH=%0b iAddr=%0h want 1/05", FETCH, iAddr);
        end
      end
      if (c == 3) begin
        vectors++;
        if ({ins_valid, ins_pc} !== {1'b1, 8'h05}) begin
          miscompares++;
          $display("FAIL halt_restart_pc: valid=%0b pc=%0h want 1/05", ins_valid, ins_pc);
        end
      end
      model_advance();
    end
  endtask

  task automatic test_async_reset();
    fill_queue();
    @(negedge clk);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ins_valid, FETCH, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset: valid=%0b FETCH=%0b busy=%0b want 0/0/0", ins_valid, FETCH, busy);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    model_advance();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      idle_inputs();
      ins_ready = 1'b1;
      settle();
      vectors++;
      if ({FETCH, busy, ins_valid} !== 3'b000) begin
        miscompares++;
        $display("FAIL async_idle_c%0d: FETCH=%0b busy=%0b valid=%0b want 0/0/0", c, FETCH, busy, ins_valid);
      end
      model_advance();
    end
  endtask

  task automatic test_wrap();
    logic [7:0] got[$];
    int         zero_fetch;
    zero_fetch = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      idle_inputs();
      start      = (c == 0);
      start_addr = 8'hFE;
      ins_ready  = 1'b1;
      settle();
      if (ins_valid === 1'b1) got.push_back(ins_pc);
      if (FETCH === 1'b1 && iAddr === 8'h00) zero_fetch++;
      model_advance();
    end
`ifdef IFETCH_WRAP_FAULT_EN
    vectors++;
    if (got.size() != 2) begin
      miscompares++;
      $display("FAIL wrap_fault_count: got %0d deliveries want 2", got.size());
    end else if (got[0] !== 8'hFE || got[1] !== 8'hFF) begin
      miscompares++;
      $display("FAIL wrap_fault_order: got %0h,%0h want FE,FF", got[0], got[1]);
    end
    vectors++;
    if ({fault, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL wrap_fault_state: fault=%0b busy=%0b want 1/0", fault, busy);
    end
    vectors++;
    if (zero_fetch != 0) begin
      miscompares++;
      $display("FAIL wrap_fault_nofetch: %0d fetches of 00 want 0", zero_fetch);
    end
`else
    vectors++;
    if (got.size() < 4) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d deliveries want at least 4", got.size());
    end else if ({got[0], got[1], got[2], got[3]} !== 32'hFEFF0001) begin
      miscompares++;
      $display("FAIL wrap_order: got %0h,%0h,%0h,%0h want FE,FF,00,01", got[0], got[1], got[2], got[3]);
    end
    vectors++;
    if ({fault, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL wrap_state: fault=%0b busy=%0b want 0/1", fault, busy);
    end
`endif
  endtask

  task automatic test_random();
    bit flushed;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    model_advance();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ins_ready     = ($urandom_range(0, 9) < 7);
      redirect      = ($urandom_range(0, 19) == 0);
      redirect_addr = 8'($urandom);
      halt_req      = ($urandom_range(0, 29) == 0);
      start         = ($urandom_range(0, 3) == 0);
      start_addr    = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
      settle();
      vectors++;
      if (FETCH !== e_fetch || (e_fetch && iAddr !== e_iaddr)) begin
        miscompares++;
        $display("FAIL rnd_fetch cyc=%0d: FETCH=%0b iAddr=%0h want %0b/%0h", c, FETCH, iAddr, e_fetch, e_iaddr);
      end
      vectors++;
      if (ins_valid !== e_valid || (e_valid && (ins_pc !== e_pc || ins_out !== e_out))) begin
        miscompares++;
        $display("FAIL rnd_deliver cyc=%0d: valid=%0b pc=%0h out=%0h want %0b/%0h/%0h", c, ins_valid, ins_pc,
                 ins_out, e_valid, e_pc, e_out);
      end
      vectors++;
      if (busy !== e_busy || fault !== m_fault) begin
        miscompares++;
        $display("FAIL rnd_status cyc=%0d: busy=%0b fault=%0b want %0b/%0b", c, busy, fault, e_busy, m_fault);
      end
      flushed = ((m_mode == M_IDLE || m_mode == M_HALT) && start) ||
                ((m_mode == M_RUN || m_mode == M_DRAIN) && redirect);
      if (flushed) obs_out = 0;
      else obs_out = obs_out + (FETCH === 1'b1 ? 1 : 0) - ((ins_valid === 1'b1 && ins_ready) ? 1 : 0);
      vectors++;
      if (obs_out > 2 || obs_out < 0) begin
        miscompares++;
        $display("FAIL rnd_occupancy cyc=%0d: outstanding=%0d want 0..2", c, obs_out);
      end
      model_advance();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    test_reset();
    test_start();
    test_backpressure();
    test_redirect();
    test_halt();
    test_async_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
